// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path
//   state_e                    receiver FSM states
//   UART_DATA_BITS             bits per character
//   UART_DEFAULT_CLKS_PER_BIT  100 MHz / 115200 baud
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_e;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver-to-FIFO byte stream plus status strobes
//   o_data_uart   last good byte
//   o_valid_uart  one-cycle strobe, data valid same cycle
//   o_frame_err   one-cycle strobe, stop bit sampled low
//   o_parity_err  one-cycle strobe, parity mismatch
//   o_busy        receiver not idle
//   master: receiver side, slave: consumer side
interface uart_rx_if;
  import uart_pkg::*;
  logic [UART_DATA_BITS-1:0] o_data_uart;
  logic o_valid_uart;
  logic o_frame_err;
  logic o_parity_err;
  logic o_busy;
  modport master (output o_data_uart, o_valid_uart, o_frame_err, o_parity_err, o_busy);
  modport slave (input o_data_uart, o_valid_uart, o_frame_err, o_parity_err, o_busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, both flops load RST_VAL
//   i_d      asynchronous input
//   o_q      synchronized output
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] ff_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ff_q <= {2{RST_VAL}};
    else ff_q <= {ff_q[0], i_d};
  assign o_q = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver, LSB first, feeding the byte FIFO
//   i_clk_wr  UART-domain clock
//   i_rst_n   asynchronous active-low reset
//   i_rx      raw serial line, idles high
//   bus       uart_rx_if.master: data/valid/frame_err/parity_err/busy
// Build option: define UART_RX_PARITY_EN to insert a parity bit between
// the data and stop bits (sense set by PARITY_ODD).
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic i_clk_wr,
  input  logic i_rst_n,
  input  logic i_rx,
  uart_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  logic rx_s;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, busy_q, busy_d;
  logic par_bad_q, par_bad_d;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk  (i_clk_wr),
    .i_rst_n(i_rst_n),
    .i_d    (i_rx),
    .o_q    (rx_s)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    par_bad_d = par_bad_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        idx_d     = '0;
        par_bad_d = 1'b0;
        state_d   = rx_s ? IDLE : START;
      end
      START:
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      DATA:
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      // Only reachable with parity compiled in; otherwise par_bad stays 0.
      PARITY:
        if (cnt_q == FULL) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q) ^ PARITY_ODD;
          state_d   = STOP;
        end
      // Stop is sampled mid-bit and we return to IDLE at once, leaving half
      // a bit of margin so a back-to-back start edge is not missed.
      STOP:
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            valid_d = !par_bad_q;
            perr_d  = par_bad_q;
            data_d  = par_bad_q ? data_q : shift_q;
          end else begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end
      // Wait out a held-low line (break) so it cannot look like a start bit.
      RECOVER: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : RECOVER;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_clk_wr or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_bad_q <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_bad_q <= par_bad_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      busy_q    <= busy_d;
    end
  assign bus.o_data_uart  = data_q;
  assign bus.o_valid_uart = valid_q;
  assign bus.o_frame_err  = ferr_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nvalid = 0;
  int nferr = 0;
  int nperr = 0;
  int nboth = 0;
  int nbusy = 0;
  int vcyc = 0;
  logic [7:0] vdata[$];
  uart_rx_if bus ();
  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .i_clk_wr(clk),
    .i_rst_n (rst_n),
    .i_rx    (rx),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n) begin
      if (bus.o_valid_uart) begin
        nvalid++;
        vdata.push_back(bus.o_data_uart);
        vcyc = cyc;
      end
      if (bus.o_frame_err) nferr++;
      if (bus.o_parity_err) nperr++;
      if (bus.o_valid_uart && bus.o_frame_err) nboth++;
      if (bus.o_busy) nbusy++;
    end
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits({1'b0, stop, d, 1'b0}, 10);
  endtask
  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.o_data_uart !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.o_data_uart); end
    total++; if (bus.o_valid_uart !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid_uart); end
    total++; if (bus.o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", bus.o_frame_err); end
    total++; if (bus.o_parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", bus.o_parity_err); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_single;
    int v0, f0, t0, lat;
    v0 = nvalid; f0 = nferr; t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    lat = vcyc - t0;
    total++; if (nvalid - v0 !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", nvalid - v0); end
    total++; if (vdata[v0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", vdata[v0]); end
    total++; if (nferr - f0 !== 0) begin bad++; $display("FAIL single_ferr: got %0d want 0", nferr - f0); end
    total++; if (lat < 152 || lat > 156) begin bad++; $display("FAIL single_latency: got %0d want 154+-2", lat); end
  endtask
  task automatic test_glitch;
    int v0, f0, b0;
    v0 = nvalid; f0 = nferr; b0 = nbusy;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    total++; if (nbusy <= b0) begin bad++; $display("FAIL glitch_busy_rise: got %0d busy cycles want >0", nbusy - b0); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_fall: got %b want 0", bus.o_busy); end
    total++; if (nvalid - v0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", nvalid - v0); end
    total++; if (nferr - f0 !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", nferr - f0); end
  endtask
  task automatic test_frame_err;
    int v0, f0;
    v0 = nvalid; f0 = nferr;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (nferr - f0 !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", nferr - f0); end
    total++; if (nvalid - v0 !== 0) begin bad++; $display("FAIL ferr_valid: got %0d want 0", nvalid - v0); end
    total++; if (bus.o_data_uart !== 8'hA5) begin bad++; $display("FAIL ferr_data_kept: got %h want a5", bus.o_data_uart); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy: got %b want 0", bus.o_busy); end
    total++; if (nboth !== 0) begin bad++; $display("FAIL ferr_overlap: got %0d want 0", nboth); end
    send_frame(8'h01, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (nvalid - v0 !== 1) begin bad++; $display("FAIL after_ferr_count: got %0d want 1", nvalid - v0); end
    total++; if (vdata[v0] !== 8'h01) begin bad++; $display("FAIL after_ferr_data: got %h want 01", vdata[v0]); end
  endtask
  task automatic test_back_to_back;
    int v0;
    logic [7:0] exp [3];
    exp = '{8'h00, 8'hFF, 8'h55};
    v0 = nvalid;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    repeat (20) @(negedge clk);
    total++; if (nvalid - v0 !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", nvalid - v0); end
    for (int i = 0; i < 3; i++) begin
      total++; if (vdata.size() <= v0 + i || vdata[v0 + i] !== exp[i]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, (vdata.size() > v0 + i) ? vdata[v0 + i] : 8'hxx, exp[i]); end
    end
  endtask
  task automatic test_reset_mid;
    int v0;
    send_bits({1'b0, 1'b1, 8'h81, 1'b0}, 4);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", bus.o_busy); end
    rst_n = 1'b0;
    #2;
    total++; if (bus.o_data_uart !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", bus.o_data_uart); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
    total++; if ({bus.o_valid_uart, bus.o_frame_err, bus.o_parity_err} !== 3'b000) begin bad++; $display("FAIL midrst_strobes: got %b want 000", {bus.o_valid_uart, bus.o_frame_err, bus.o_parity_err}); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    v0 = nvalid;
    repeat (20) @(negedge clk);
    total++; if (nvalid - v0 !== 0) begin bad++; $display("FAIL midrst_nostrobe: got %0d want 0", nvalid - v0); end
    send_frame(8'h7E, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (nvalid - v0 !== 1) begin bad++; $display("FAIL midrst_next_count: got %0d want 1", nvalid - v0); end
    total++; if (bus.o_data_uart !== 8'h7E) begin bad++; $display("FAIL midrst_next_data: got %h want 7e", bus.o_data_uart); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = nvalid; p0 = nperr;
    send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (20) @(negedge clk);
    total++; if (nvalid - v0 !== 1) begin bad++; $display("FAIL par_good_count: got %0d want 1", nvalid - v0); end
    total++; if (bus.o_data_uart !== 8'h07) begin bad++; $display("FAIL par_good_data: got %h want 07", bus.o_data_uart); end
    total++; if (nperr - p0 !== 0) begin bad++; $display("FAIL par_good_perr: got %0d want 0", nperr - p0); end
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (20) @(negedge clk);
    total++; if (nperr - p0 !== 1) begin bad++; $display("FAIL par_bad_perr: got %0d want 1", nperr - p0); end
    total++; if (nvalid - v0 !== 1) begin bad++; $display("FAIL par_bad_valid: got %0d want 1", nvalid - v0); end
  endtask
`else
  task automatic test_parity;
    total++; if (nperr !== 0) begin bad++; $display("FAIL no_parity_perr: got %0d want 0", nperr); end
  endtask
`endif
  initial begin
    test_reset;
    test_single;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_parity;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
